// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;
  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam logic OP_MULT  = 1'b0;
  localparam logic OP_DIV   = 1'b1;
  localparam int   ITER_CNT = 32;
  localparam int   CNT_W    = 6;
endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between a requester (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(parameter int DATA_W = 32);
  logic              start;
  logic              op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;
  logic              div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/md_sign_fix.sv
// Two's-complement conditional negation; with i_neg = MSB of i_val it yields |i_val|.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_res
);
  assign o_res = i_neg ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / 32/32 divide: 32 unsigned steps on magnitudes, then a sign-fix cycle.
// Optional macro MULTDIV_DIVZERO_EXC_EN: divide by zero finishes immediately and pulses div_zero.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  mult_div_unit_if.slave  bus
);
  state_t              r_state;
  state_t              w_state_next;
  logic                r_op;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [CNT_W-1:0]    r_cnt;

  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [2*DATA_W-1:0] w_prod_s;
  logic [DATA_W-1:0]   w_quo_s;
  logic [DATA_W-1:0]   w_rem_s;
  logic                w_iter_done;
  logic                w_dz_take;
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W:0]     w_div_shift;
  logic [DATA_W-1:0]   w_div_sub;
  logic                w_div_ok;

  md_sign_fix #(.W(DATA_W)) u_abs_a (
    .i_val(bus.a), .i_neg(bus.a[DATA_W-1]), .o_res(w_a_mag)
  );
  md_sign_fix #(.W(DATA_W)) u_abs_b (
    .i_val(bus.b), .i_neg(bus.b[DATA_W-1]), .o_res(w_b_mag)
  );
  md_sign_fix #(.W(2*DATA_W)) u_fix_prod (
    .i_val({r_rem, r_quo}), .i_neg(r_neg_q), .o_res(w_prod_s)
  );
  md_sign_fix #(.W(DATA_W)) u_fix_quo (
    .i_val(r_quo), .i_neg(r_neg_q), .o_res(w_quo_s)
  );
  md_sign_fix #(.W(DATA_W)) u_fix_rem (
    .i_val(r_rem), .i_neg(r_neg_r), .o_res(w_rem_s)
  );

  // The counter reaches ITER_CNT after the last step; that cycle only hands over to FIX.
  assign w_iter_done = (r_cnt == CNT_W'(ITER_CNT));

`ifdef MULTDIV_DIVZERO_EXC_EN
  logic r_dz;
  assign w_dz_take    = bus.start && (bus.op == OP_DIV) && (bus.b == '0);
  assign bus.div_zero = (r_state == DONE) && r_dz;
`else
  assign w_dz_take    = 1'b0;
  assign bus.div_zero = 1'b0;
`endif

  // Shift-add: r_rem:r_quo is the 64-bit product register, multiplier bits leave from r_quo[0].
  assign w_mul_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvs} : '0);

  // Restoring divide: dividend bits shift out of r_quo's MSB, quotient bits shift in at its LSB.
  assign w_div_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_dvs});
  assign w_div_sub   = w_div_shift[DATA_W-1:0] - r_dvs;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_dz_take) begin
            w_state_next = DONE;
          end else if (bus.op == OP_DIV) begin
            w_state_next = DIV;
          end else begin
            w_state_next = MULT;
          end
        end
      end
      MULT, DIV: begin
        if (w_iter_done) begin
          w_state_next = FIX;
        end
      end
      FIX:     w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op    <= OP_MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
`ifdef MULTDIV_DIVZERO_EXC_EN
      r_dz    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_neg_q <= bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
            r_neg_r <= bus.a[DATA_W-1];
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
`ifdef MULTDIV_DIVZERO_EXC_EN
            r_dz    <= w_dz_take;
`endif
          end
        end
        MULT: begin
          if (!w_iter_done) begin
            r_rem <= w_mul_sum[DATA_W:1];
            r_quo <= {w_mul_sum[0], r_quo[DATA_W-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DIV: begin
          if (!w_iter_done) begin
            r_rem <= w_div_ok ? w_div_sub : w_div_shift[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_div_ok};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (r_op == OP_MULT) begin
            r_hi <= w_prod_s[2*DATA_W-1:DATA_W];
            r_lo <= w_prod_s[DATA_W-1:0];
          end else begin
            r_hi <= w_rem_s;
            r_lo <= w_quo_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (r_state == MULT) || (r_state == DIV) || (r_state == FIX);
  assign bus.done = (r_state == DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
